// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between instruction fetch and data access; data normally wins.
// Latency: request seen in IDLE at cycle 0 -> mem_req from cycle 1; ack same cycle as mem_ready.
// Backpressure: requesters hold req until ack; one IDLE cycle between accesses. Option: STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                halt,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [BE_W-1:0]   r_mem_be;
  logic              w_idle;
  logic              w_fetch_ok;
  logic              w_force_i;
  logic              w_grant_d;
  logic              w_grant_i;

  assign w_idle     = (r_state == IDLE);
  assign w_fetch_ok = i_req && !halt;

`ifdef STARVE_GUARD_EN
  // Count data grants made while a fetch is waiting; a full streak hands the next slot to the fetch.
  logic [SW-1:0] r_streak;

  assign w_force_i = (r_streak == SW'(STARVE_LIMIT)) && w_fetch_ok;

  // Streak bookkeeping happens only at arbitration time (IDLE); saturates while halt blocks fetches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_streak <= '0;
    end else if (w_idle) begin
      if (!i_req || w_grant_i) begin
        r_streak <= '0;
      end else if (w_grant_d && (r_streak != SW'(STARVE_LIMIT))) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end
`else
  // Strict data priority: the starvation limit has no effect in this build.
  logic [SW-1:0] w_unused_starve_limit;
  assign w_unused_starve_limit = SW'(STARVE_LIMIT);
  assign w_force_i = 1'b0;
`endif

  // Older instruction (data) wins unless the starvation guard forces a fetch.
  assign w_grant_d = w_idle && d_req && !w_force_i;
  assign w_grant_i = w_idle && w_fetch_ok && !w_grant_d;

  // Next-state selection: grant from IDLE, return to IDLE on the memory's completion.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_d)      w_next_state = BUSY_D;
        else if (w_grant_i) w_next_state = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register; reset aborts any in-flight access without an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Capture the winner's request at grant so memory outputs stay stable for the whole access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else if (w_grant_d) begin
      r_mem_we    <= d_we;
      r_mem_addr  <= d_addr;
      r_mem_wdata <= d_wdata;
      r_mem_be    <= d_we ? d_be : {BE_W{1'b1}};
    end else if (w_grant_i) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= i_addr;
      r_mem_wdata <= '0;
      r_mem_be    <= {BE_W{1'b1}};
    end
  end

  assign busy      = !w_idle;
  assign mem_req   = busy;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

  assign i_ack   = (r_state == BUSY_I) && mem_ready;
  assign d_ack   = (r_state == BUSY_D) && mem_ready;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, priority, wait states, halt, async reset, starvation.
// Inputs change 2 time units after the rising edge; outputs are sampled before the next edge.
// Expected values are hand-derived per step; the starvation pattern follows STARVE_GUARD_EN.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        halt;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;

  int vectors;
  int miscompares;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_fetch;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; halt = 1'b0;
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;

    // 1. reset with fetch pending, then first fetch
    tick(); tick();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_i_ack", {31'b0, i_ack}, 32'd0);
    chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    reset = 1'b0;
    tick();
    chk("f1_mem_req", {31'b0, mem_req}, 32'd1);
    chk("f1_mem_addr", mem_addr, 32'h100);
    chk("f1_mem_we", {31'b0, mem_we}, 32'd0);
    chk("f1_mem_be", {28'b0, mem_be}, 32'hF);
    chk("f1_i_ack_wait", {31'b0, i_ack}, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1;
    chk("f1_i_ack", {31'b0, i_ack}, 32'd1);
    chk("f1_i_rdata", i_rdata, 32'hCAFEF00D);
    chk("f1_d_ack", {31'b0, d_ack}, 32'd0);
    tick();
    i_req = 1'b0;
    #1;
    chk("f1_idle_mem_req", {31'b0, mem_req}, 32'd0);
    chk("f1_idle_ready_ignored", {31'b0, i_ack}, 32'd0);

    // 2. simultaneous requests: store served first, fetch after IDLE cycle
    mem_ready = 1'b0;
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    tick();
    d_addr = 32'h44; d_wdata = 32'h0; d_be = 4'hF;
    #1;
    chk("p_mem_we", {31'b0, mem_we}, 32'd1);
    chk("p_mem_addr", mem_addr, 32'h40);
    chk("p_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("p_mem_be", {28'b0, mem_be}, 32'h3);
    mem_ready = 1'b1;
    #1;
    chk("p_d_ack", {31'b0, d_ack}, 32'd1);
    chk("p_i_ack", {31'b0, i_ack}, 32'd0);
    tick();
    d_req = 1'b0; mem_ready = 1'b0;
    #1;
    chk("p_gap_busy", {31'b0, busy}, 32'd0);
    tick();
    chk("p_fetch_addr", mem_addr, 32'h200);
    chk("p_fetch_we", {31'b0, mem_we}, 32'd0);
    chk("p_fetch_be", {28'b0, mem_be}, 32'hF);
    chk("p_fetch_wdata", mem_wdata, 32'h0);
    mem_ready = 1'b1;
    #1;
    chk("p_fetch_ack", {31'b0, i_ack}, 32'd1);
    tick();
    i_req = 1'b0; mem_ready = 1'b0;

    // 3. load with 3 wait cycles
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_be = 4'h1; d_wdata = 32'h55;
    tick();
    chk("w_load_be", {28'b0, mem_be}, 32'hF);
    chk("w_load_we", {31'b0, mem_we}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("w_hold_req", {31'b0, mem_req}, 32'd1);
      chk("w_hold_addr", mem_addr, 32'h80);
      chk("w_hold_no_ack", {31'b0, d_ack}, 32'd0);
      tick();
    end
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    #1;
    chk("w_req_4th", {31'b0, mem_req}, 32'd1);
    chk("w_addr_4th", mem_addr, 32'h80);
    chk("w_d_ack", {31'b0, d_ack}, 32'd1);
    chk("w_d_rdata", d_rdata, 32'h12345678);
    tick();
    d_req = 1'b0; mem_ready = 1'b0;
    #1;
    chk("w_ack_pulse", {31'b0, d_ack}, 32'd0);
    chk("w_req_drop", {31'b0, mem_req}, 32'd0);

    // 4. halt blocks fetch but not data
    halt = 1'b1; i_req = 1'b1; i_addr = 32'h300;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("h_no_grant", {31'b0, busy}, 32'd0);
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90;
    tick();
    chk("h_data_busy", {31'b0, busy}, 32'd1);
    chk("h_data_addr", mem_addr, 32'h90);
    mem_ready = 1'b1;
    #1;
    chk("h_data_ack", {31'b0, d_ack}, 32'd1);
    tick();
    d_req = 1'b0; mem_ready = 1'b0;
    tick();
    chk("h_still_blocked", {31'b0, busy}, 32'd0);
    halt = 1'b0;
    tick();
    chk("h_fetch_busy", {31'b0, busy}, 32'd1);
    chk("h_fetch_addr", mem_addr, 32'h300);
    halt = 1'b1; mem_ready = 1'b1;
    #1;
    chk("h_inflight_ack", {31'b0, i_ack}, 32'd1);
    tick();
    i_req = 1'b0; halt = 1'b0; mem_ready = 1'b0;

    // 5. async reset during BUSY_D
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'hA0; d_wdata = 32'h1; d_be = 4'hF;
    tick();
    chk("r_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("r_mem_req_drop", {31'b0, mem_req}, 32'd0);
    chk("r_no_d_ack", {31'b0, d_ack}, 32'd0);
    chk("r_addr_clear", mem_addr, 32'h0);
    mem_ready = 1'b1;
    #1;
    chk("r_no_d_ack_ready", {31'b0, d_ack}, 32'd0);
    tick();
    reset = 1'b0; mem_ready = 1'b0;
    d_we = 1'b0; d_addr = 32'hB0;
    tick();
    chk("r_fresh_busy", {31'b0, busy}, 32'd1);
    chk("r_fresh_addr", mem_addr, 32'hB0);
    mem_ready = 1'b1;
    #1;
    chk("r_fresh_ack", {31'b0, d_ack}, 32'd1);
    tick();
    d_req = 1'b0; mem_ready = 1'b0;

    // 6. continuous data + fetch contention with a 0-wait memory
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'hC0;
    i_req = 1'b1; i_addr = 32'hD0;
    mem_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
`ifdef STARVE_GUARD_EN
      exp_fetch = ((n % 5) == 4);
`else
      exp_fetch = 1'b0;
`endif
      tick();
      chk("s_i_ack", {31'b0, i_ack}, {31'b0, exp_fetch});
      chk("s_d_ack", {31'b0, d_ack}, {31'b0, !exp_fetch});
      chk("s_addr", mem_addr, exp_fetch ? 32'hD0 : 32'hC0);
      tick();
      chk("s_gap", {31'b0, busy}, 32'd0);
    end
    d_req = 1'b0; i_req = 1'b0; mem_ready = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
